ita_max_stream: RTL

Streaming, row-indexed running-maximum unit for the softmax datapath. It accepts N-lane signed beats through a valid/ready handshake and reduces each beat with a masked comparison tree. It keeps an independent running maximum for each of ROWS rows and emits the updated maximum together with its increase, which the downstream normaliser uses to rescale partial sums. It sits between the requantiser output and the softmax accumulator and extends the single-beat max finder with parametrised width and lane count, multi-row state, lane masking, pipelining and backpressure.

---
 rtl/ita_max_stream_pkg.sv | 20 ++
 rtl/ita_max_stream_if.sv | 42 ++++
 rtl/ita_max_stream_tree.sv | 33 +++
 rtl/ita_max_stream.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ita_max_stream_pkg.sv
// Shared types and helpers for the streaming running-max unit.
// Holds WIDTH-independent items only; lane types live in the modules.
package ita_max_stream_pkg;

  localparam int MAX_STREAM_ROWS = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MAX_STREAM_RW = idx_width(MAX_STREAM_ROWS);

  typedef logic [MAX_STREAM_RW-1:0] max_stream_row_t;

  typedef struct packed {
    logic first;
    logic last;
  } beat_flags_t;

endpackage

// File: rtl/ita_max_stream_if.sv
// Beat/result handshake bundle for ita_max_stream.
// slave: DUT view (beats in, results out); master: upstream/downstream view.
interface ita_max_stream_if #(
  parameter int N     = 16,
  parameter int WIDTH = 8,
  parameter int RW    = 2
);

  logic             valid_i;
  logic             ready_o;
  logic [N*WIDTH-1:0] data_i;
  logic [N-1:0]     mask_i;
  logic [RW-1:0]    row_i;
  logic             first_i;
  logic             last_i;

  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] max_o;
  logic [WIDTH-1:0] max_diff_o;
  logic [RW-1:0]    row_o;
  logic             last_o;

  modport slave (
    input  valid_i, data_i, mask_i,
    input  row_i, first_i, last_i,
    input  ready_i,
    output ready_o,
    output valid_o, max_o, max_diff_o,
    output row_o, last_o
  );

  modport master (
    output valid_i, data_i, mask_i,
    output row_i, first_i, last_i,
    output ready_i,
    input  ready_o,
    input  valid_o, max_o, max_diff_o,
    input  row_o, last_o
  );

endinterface

// File: rtl/ita_max_stream_tree.sv
// ita_max_tree: combinational masked signed max over N lanes.
// Ports: data_i (N lanes), mask_i (1 = lane used), max_o (MIN if none).
module ita_max_tree #(
  parameter int N     = 16,
  parameter int WIDTH = 8
) (
  input  logic [N*WIDTH-1:0]      data_i,
  input  logic [N-1:0]            mask_i,
  output logic signed [WIDTH-1:0] max_o
);

  localparam logic signed [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  // Heap layout: node i has children 2i+1, 2i+2;
  // leaves occupy N-1 .. 2N-2, giving log2(N) levels.
  logic signed [WIDTH-1:0] node [2*N-1];

  for (genvar k = 0; k < N; k++) begin : g_leaf
    assign node[N-1+k] = mask_i[k]
      ? $signed(data_i[k*WIDTH +: WIDTH])
      : MIN;
  end

  for (genvar i = 0; i < N-1; i++) begin : g_node
    assign node[i] = (node[2*i+1] >= node[2*i+2])
      ? node[2*i+1]
      : node[2*i+2];
  end

  assign max_o = node[0];

endmodule

// File: rtl/ita_max_stream.sv
// Row-indexed streaming running max with increase, two-stage pipeline.
// Ports: clk_i, rst_i (async high), clear_i (sync flush), s (beat/result bus).
module ita_max_stream
  import ita_max_stream_pkg::*;
#(
  parameter int N     = 16,
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int RW    = idx_width(ROWS)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  ita_max_stream_if.slave s
);

  typedef logic signed [WIDTH-1:0] lane_t;

  localparam lane_t MIN = {1'b1, {(WIDTH-1){1'b0}}};

  lane_t       beat_max;
  logic        enable;
  logic        accept;
  lane_t       prev;
  lane_t       new_max;
  logic [WIDTH-1:0] diff;

  logic        s1_valid_q, s1_valid_d;
  lane_t       s1_max_q, s1_max_d;
  logic [RW-1:0] s1_row_q, s1_row_d;
  beat_flags_t s1_flags_q, s1_flags_d;

  logic        valid_q, valid_d;
  lane_t       max_q, max_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [RW-1:0] row_q, row_d;
  logic        last_q, last_d;

  lane_t       entry_q [ROWS];
  lane_t       entry_d [ROWS];

  ita_max_tree #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_tree (
    .data_i (s.data_i),
    .mask_i (s.mask_i),
    .max_o  (beat_max)
  );

  always_comb begin
    enable  = !valid_q || s.ready_i;
    accept  = s.valid_i && enable && !clear_i;

    prev    = s1_flags_q.first ? MIN : entry_q[s1_row_q];
    new_max = (s1_max_q > prev) ? s1_max_q : prev;
    // new >= prev, so the true difference is 0..2^WIDTH-1 and
    // the low WIDTH bits of the wrap-around subtraction are exact.
    diff    = s1_flags_q.first
      ? '0
      : WIDTH'(new_max - prev);

    s1_valid_d = s1_valid_q;
    s1_max_d   = s1_max_q;
    s1_row_d   = s1_row_q;
    s1_flags_d = s1_flags_q;
    valid_d    = valid_q;
    max_d      = max_q;
    diff_d     = diff_q;
    row_d      = row_q;
    last_d     = last_q;
    entry_d    = entry_q;

    if (clear_i) begin
      s1_valid_d = 1'b0;
      valid_d    = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        entry_d[r] = MIN;
      end
    end else if (enable) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_max_d   = beat_max;
        s1_row_d   = s.row_i;
        s1_flags_d = '{first: s.first_i, last: s.last_i};
      end
      valid_d = s1_valid_q;
      if (s1_valid_q) begin
        max_d  = new_max;
        diff_d = diff;
        row_d  = s1_row_q;
        last_d = s1_flags_q.last;
        for (int r = 0; r < ROWS; r++) begin
          if (s1_row_q == RW'(r)) begin
            entry_d[r] = new_max;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_max_q   <= MIN;
      s1_row_q   <= '0;
      s1_flags_q <= '0;
      valid_q    <= 1'b0;
      max_q      <= '0;
      diff_q     <= '0;
      row_q      <= '0;
      last_q     <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        entry_q[r] <= MIN;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_max_q   <= s1_max_d;
      s1_row_q   <= s1_row_d;
      s1_flags_q <= s1_flags_d;
      valid_q    <= valid_d;
      max_q      <= max_d;
      diff_q     <= diff_d;
      row_q      <= row_d;
      last_q     <= last_d;
      for (int r = 0; r < ROWS; r++) begin
        entry_q[r] <= entry_d[r];
      end
    end
  end

  assign s.ready_o    = enable && !clear_i;
  assign s.valid_o    = valid_q;
  assign s.max_o      = max_q;
  assign s.max_diff_o = diff_q;
  assign s.row_o      = row_q;
  assign s.last_o     = last_q;

endmodule
